ami_spi_reader: RTL

Register read-back engine for the AMI SPI devices: the read counterpart of the write-only AFE SPI path. Accepts a chip/address command on a valid/ready handshake, drives CSB/SCLK/SDI for one read frame, deserializes SDO and returns the data word with a one-cycle valid strobe. Sits in the system-clock domain between the processor register block and the `AMI_SPI_*` pins.

---
 rtl/ami_spi_pkg.sv | 23 ++
 rtl/ami_spi_reader_if.sv | 28 ++
 rtl/ami_spi_bit_timer.sv | 49 ++++
 rtl/ami_spi_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ami_spi_pkg.sv
// Shared types and constants for the AMI SPI read-back engine.
// Frame layout: read flag, register address, then the data turnaround bits.
package ami_spi_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SHIFT = 2'd1;
  localparam spi_state_t ST_HOLD  = 2'd2;
  localparam spi_state_t ST_GAP   = 2'd3;

  // First bit on the wire marks the frame as a read.
  localparam logic READ_BIT = 1'b1;

  function automatic int frame_len(input int addr_width, input int data_width);
    return 1 + addr_width + data_width;
  endfunction

  function automatic int chip_width(input int chip_count);
    return (chip_count > 1) ? $clog2(chip_count) : 1;
  endfunction

endpackage

// File: rtl/ami_spi_reader_if.sv
// Command / read-data handshake between the register block and the reader.
// The register block is the master; the SPI reader is the slave.
interface ami_spi_reader_if #(
  parameter int CHIP_W     = 1,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24
);

  logic                  cmdValid;
  logic                  cmdReady;
  logic [CHIP_W-1:0]     cmdChip;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic                  rdValid;
  logic [CHIP_W-1:0]     rdChip;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  busy;

  modport master (
    output cmdValid, cmdChip, cmdAddr,
    input  cmdReady, rdValid, rdChip, rdData, busy
  );

  modport slave (
    input  cmdValid, cmdChip, cmdAddr,
    output cmdReady, rdValid, rdChip, rdData, busy
  );

endinterface

// File: rtl/ami_spi_bit_timer.sv
// Per-bit SCLK timer: 2*CLK_DIV cycles per bit, flags the cycle that ends the
// low phase and the cycle that ends the high phase.
module ami_spi_bit_timer #(
  parameter int CLK_DIV = 5
) (
  input  logic sysClk,
  input  logic sysReset_n,
  input  logic restart,
  input  logic enable,
  output logic lowStart,
  output logic riseStrobe,
  output logic sampleStrobe,
  output logic bitDone
);

  localparam int BIT_CYCLES = 2 * CLK_DIV;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_LOW  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_HIGH = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_high;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST_HIGH) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sampling, the SCLK fall (start of next low phase) and the end of the bit
  // all fall on the last high-phase cycle; the parent registers the outputs.
  assign last_high    = enable && (cnt_q == LAST_HIGH);
  assign riseStrobe   = enable && (cnt_q == LAST_LOW);
  assign lowStart     = last_high;
  assign sampleStrobe = last_high;
  assign bitDone      = last_high;

endmodule

// File: rtl/ami_spi_reader.sv
// AMI SPI register read-back engine: one command in, one read frame on the
// pins, one data word out with a single-cycle valid strobe.
module ami_spi_reader
  import ami_spi_pkg::*;
#(
  parameter int CHIP_COUNT = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 5,
  parameter int CS_GAP     = 4
) (
  input  logic                  sysClk,
  input  logic                  sysReset_n,
  ami_spi_reader_if.slave       bus,
  output logic                  spiClk,
  output logic                  spiSdi,
  output logic [CHIP_COUNT-1:0] spiCsb,
  input  logic [CHIP_COUNT-1:0] spiSdo
);

  localparam int N          = frame_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int CHIP_W     = chip_width(CHIP_COUNT);
  localparam int TX_W       = N - 1;
  localparam int BIT_W      = $clog2(N);
  localparam int GAP_W      = $clog2(CS_GAP + 1);
  localparam int DATA_START = 1 + ADDR_WIDTH;

  spi_state_t            state_q, state_d;
  logic                  busy_q, busy_d;
  logic [CHIP_W-1:0]     chip_q, chip_d;
  logic [TX_W-1:0]       tx_q, tx_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  sclk_q, sclk_d;
  logic                  sdi_q, sdi_d;
  logic [CHIP_COUNT-1:0] csb_q, csb_d;
  logic [CHIP_COUNT-1:0] sdo_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CHIP_W-1:0]     rd_chip_q, rd_chip_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic timer_restart, timer_enable;
  logic low_start, rise_strobe, sample_strobe, bit_done;

  logic [CHIP_COUNT-1:0] cmd_hit, sel_hit, sdo_hit;
  logic                  sdo_bit;

  // An out-of-range chip index matches no select line: no CSB, SDO reads 1.
  genvar gi;
  for (gi = 0; gi < CHIP_COUNT; gi++) begin : g_chip
    assign cmd_hit[gi] = (bus.cmdChip == CHIP_W'(gi));
    assign sel_hit[gi] = (chip_q == CHIP_W'(gi));
    assign sdo_hit[gi] = sel_hit[gi] & sdo_q[gi];
  end

  assign sdo_bit = (|sdo_hit) | ~(|sel_hit);

  assign timer_enable = (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  ami_spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .sysClk       (sysClk),
    .sysReset_n   (sysReset_n),
    .restart      (timer_restart),
    .enable       (timer_enable),
    .lowStart     (low_start),
    .riseStrobe   (rise_strobe),
    .sampleStrobe (sample_strobe),
    .bitDone      (bit_done)
  );

  always_comb begin
    state_d       = state_q;
    chip_d        = chip_q;
    tx_d          = tx_q;
    bit_d         = bit_q;
    gap_d         = gap_q;
    sclk_d        = sclk_q;
    sdi_d         = sdi_q;
    csb_d         = csb_q;
    shift_d       = shift_q;
    rd_valid_d    = 1'b0;
    rd_chip_d     = rd_chip_q;
    rd_data_d     = rd_data_q;
    timer_restart = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmdValid) begin
          state_d       = ST_SHIFT;
          chip_d        = bus.cmdChip;
          tx_d          = {bus.cmdAddr, {DATA_WIDTH{1'b0}}};
          sdi_d         = READ_BIT;
          csb_d         = ~cmd_hit;
          bit_d         = '0;
          shift_d       = '0;
          timer_restart = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (rise_strobe) begin
          sclk_d = 1'b1;
        end
        if (sample_strobe && (bit_q >= BIT_W'(DATA_START))) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sdo_bit};
        end
        // Turnaround bits shift out as zeros once the address is gone.
        if (low_start) begin
          sclk_d = 1'b0;
          sdi_d  = tx_q[TX_W-1];
          tx_d   = {tx_q[TX_W-2:0], 1'b0};
        end
        if (bit_done) begin
          if (bit_q == BIT_W'(N - 1)) begin
            state_d = ST_HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (rise_strobe) begin
          state_d    = ST_GAP;
          csb_d      = '1;
          gap_d      = '0;
          rd_valid_d = 1'b1;
          rd_chip_d  = chip_q;
          rd_data_d  = shift_q;
        end
      end

      default: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      chip_q     <= '0;
      tx_q       <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      csb_q      <= '1;
      sdo_q      <= '1;
      shift_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_chip_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      chip_q     <= chip_d;
      tx_q       <= tx_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      csb_q      <= csb_d;
      sdo_q      <= spiSdo;
      shift_q    <= shift_d;
      rd_valid_q <= rd_valid_d;
      rd_chip_q  <= rd_chip_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign spiClk       = sclk_q;
  assign spiSdi       = sdi_q;
  assign spiCsb       = csb_q;
  assign bus.cmdReady = ~busy_q;
  assign bus.busy     = busy_q;
  assign bus.rdValid  = rd_valid_q;
  assign bus.rdChip   = rd_chip_q;
  assign bus.rdData   = rd_data_q;

endmodule
